// File: rtl/wb_defs.sv
// wb_defs: shared Wishbone constants and DMA copy state encoding
package wb_defs;
   typedef enum logic [2:0] {IDLE, RD, RGAP, WR, WGAP, FIN, ABORT} state_t;
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [3:0] SEL_ALL = 4'hF;
endpackage

// File: rtl/wb_dma_copy.sv
// wb_dma_copy: word-by-word Wishbone memory copy engine with ack timeout
module wb_dma_copy
   import wb_defs::*;
#(
   parameter int TIMEOUT = 1023
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        start_i,
   input  logic [31:0] src_i,
   input  logic [31:0] dst_i,
   input  logic [15:0] len_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] m_adr_o,
   output logic [31:0] m_dat_o,
   output logic [2:0]  m_cti_o,
   output logic [3:0]  m_sel_o,
   output logic        m_we_o,
   output logic        m_cyc_o,
   output logic        m_stb_o,
   input  logic [31:0] m_dat_i,
   input  logic        m_ack_i
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

   state_t        state_q, state_d;
   logic [31:0]   src_q, src_d, dst_q, dst_d, data_q, data_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          done_q, err_q;
   logic          stb, ack;

   // the strobe is withdrawn as soon as the stall counter saturates
   assign stb = (state_q == RD || state_q == WR) && tmo_q != TMAX;
   assign ack = stb && m_ack_i;

   assign busy_o  = state_q != IDLE;
   assign done_o  = done_q;
   assign err_o   = err_q;
   assign m_cyc_o = stb;
   assign m_stb_o = stb;
   assign m_we_o  = stb && state_q == WR;
   assign m_adr_o = state_q == WR ? dst_q : src_q;
   assign m_dat_o = data_q;
   assign m_cti_o = CTI_CLASSIC;
   assign m_sel_o = SEL_ALL;

   // next-state, pointer, count and stall-counter logic
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE:
            if (start_i) begin
               src_d   = {src_i[31:2], 2'b00};
               dst_d   = {dst_i[31:2], 2'b00};
               cnt_d   = len_i;
               state_d = len_i == 16'd0 ? FIN : RD;
            end
         RD:
            if (ack) begin
               data_d  = m_dat_i;
               state_d = RGAP;
            end else if (!stb) begin
               state_d = ABORT;
            end
         RGAP: state_d = WR;
         WR:
            if (ack) begin
               src_d   = src_q + 32'd4;
               dst_d   = dst_q + 32'd4;
               cnt_d   = cnt_q - 16'd1;
               state_d = WGAP;
            end else if (!stb) begin
               state_d = ABORT;
            end
         WGAP:    state_d = cnt_q == 16'd0 ? FIN : RD;
         default: state_d = IDLE;
      endcase
      tmo_d = state_d != state_q ? '0 : (stb && !m_ack_i) ? tmo_q + TW'(1) : tmo_q;
   end

   // state registers; completion and abort pulses are registered from FIN/ABORT
   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         done_q  <= state_q == FIN;
         err_q   <= state_q == ABORT;
      end
   end
endmodule

// File: tb/tb_wb_dma_copy.sv
// tb_wb_dma_copy: randomized copy bench with a memory-backed Wishbone slave
module tb_wb_dma_copy;
   localparam int TMO = 8;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [31:0] src = '0, dst = '0;
   logic [15:0] len = '0;
   logic        busy, done, err, we, cyc, stb;
   logic [31:0] adr, dat_o;
   logic [2:0]  cti;
   logic [3:0]  sel;
   logic [31:0] sdat = '0;
   logic        sack = 1'b0;

   always #5 clk = ~clk;

   wb_dma_copy #(.TIMEOUT(TMO)) dut (
      .sys_clk(clk), .sys_rst(rst_n), .start_i(start), .src_i(src), .dst_i(dst), .len_i(len),
      .busy_o(busy), .done_o(done), .err_o(err), .m_adr_o(adr), .m_dat_o(dat_o), .m_cti_o(cti),
      .m_sel_o(sel), .m_we_o(we), .m_cyc_o(cyc), .m_stb_o(stb), .m_dat_i(sdat), .m_ack_i(sack)
   );

   int tests = 0, fails = 0;
   logic [31:0] mem [logic [31:0]];
   int lat = 0, scnt = 0;
   bit nack = 1'b0, mon_en = 1'b0;
   logic [31:0] rd_adr[$], wr_adr[$], wr_dat[$];
   int done_n = 0, err_n = 0, cyc_n = 0, cyc_cnt = 0, done_at = 0, t0 = 0;
   logic p_stb = 1'b0, p_ack = 1'b0;
   logic [64:0] p_bus = '0;

   // slave memory, transaction log and pulse counters
   always @(posedge clk) begin
      if (stb && sack) begin
         if (we) begin
            mem[adr] = dat_o;
            wr_adr.push_back(adr);
            wr_dat.push_back(dat_o);
         end else rd_adr.push_back(adr);
      end
      if (done) begin done_n++; done_at = cyc_cnt; end
      if (err) err_n++;
      if (cyc) cyc_n++;
      cyc_cnt++;
      if (!stb || sack) begin
         sack <= 1'b0;
         scnt = 0;
      end else if (!nack) begin
         if (scnt == lat) begin
            sack <= 1'b1;
            sdat <= mem.exists(adr) ? mem[adr] : 32'hDEAD_BEEF;
         end else scnt++;
      end
   end

   // bus stability across stalled strobe cycles
   always @(negedge clk) begin
      if (mon_en && stb && p_stb && !p_ack) begin
         tests++;
         if ({adr, dat_o, we} !== p_bus) begin
            fails++;
            $display("FAIL stall_stable: got %h expected %h", {adr, dat_o, we}, p_bus);
         end
      end
      p_stb = stb;
      p_ack = sack;
      p_bus = {adr, dat_o, we};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
      src = s; dst = d; len = n; start = 1'b1;
      t0 = cyc_cnt;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_logs();
      rd_adr.delete(); wr_adr.delete(); wr_dat.delete();
      done_n = 0; err_n = 0; cyc_n = 0;
   endtask

   task automatic copy(input logic [31:0] s, input logic [31:0] d, input int n, input int l, input string nm);
      logic [31:0] sa, da, w;
      logic [31:0] exp_d[$];
      int k;
      sa = s & ~32'd3;
      da = d & ~32'd3;
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         mem[sa + 32'(4 * i)] = w;
         exp_d.push_back(w);
      end
      lat = l; nack = 1'b0;
      clear_logs();
      pulse_start(s, d, 16'(n));
      k = 0;
      while (done_n == 0 && err_n == 0 && k < 2000) begin tick(); k++; end
      tests++;
      if (k >= 2000) begin fails++; $display("FAIL %s_wait: no completion within 2000 cycles", nm); end
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy: got %b expected 0", nm, busy); end
      tests++;
      if (done_at - t0 !== 6 * n + 2 + 2 * n * l) begin
         fails++; $display("FAIL %s_latency: got %0d expected %0d", nm, done_at - t0, 6 * n + 2 + 2 * n * l);
      end
      repeat (3) tick();
      tests++;
      if (done_n !== 1) begin fails++; $display("FAIL %s_done: got %0d pulses expected 1", nm, done_n); end
      tests++;
      if (err_n !== 0) begin fails++; $display("FAIL %s_err: got %0d pulses expected 0", nm, err_n); end
      tests++;
      if (rd_adr.size() !== n || wr_adr.size() !== n) begin
         fails++; $display("FAIL %s_count: got %0d reads %0d writes expected %0d", nm, rd_adr.size(), wr_adr.size(), n);
      end
      for (int i = 0; i < n && i < rd_adr.size() && i < wr_adr.size(); i++) begin
         tests++;
         if (rd_adr[i] !== sa + 32'(4 * i)) begin
            fails++; $display("FAIL %s_rd_adr[%0d]: got %h expected %h", nm, i, rd_adr[i], sa + 32'(4 * i));
         end
         tests++;
         if (wr_adr[i] !== da + 32'(4 * i)) begin
            fails++; $display("FAIL %s_wr_adr[%0d]: got %h expected %h", nm, i, wr_adr[i], da + 32'(4 * i));
         end
         tests++;
         if (wr_dat[i] !== exp_d[i]) begin
            fails++; $display("FAIL %s_wr_dat[%0d]: got %h expected %h", nm, i, wr_dat[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_reset();
      tests++;
      if ({cyc, stb, we, busy, done, err} !== 6'b0) begin
         fails++; $display("FAIL reset_ctl: got %b expected 000000", {cyc, stb, we, busy, done, err});
      end
      tests++;
      if (adr !== 32'd0 || dat_o !== 32'd0) begin fails++; $display("FAIL reset_bus: got %h/%h expected 0/0", adr, dat_o); end
      tests++;
      if (cti !== 3'b000 || sel !== 4'hF) begin fails++; $display("FAIL reset_cti_sel: got %b/%h expected 000/f", cti, sel); end
   endtask

   task automatic test_zero_wait();
      copy(32'h0000_1000, 32'h0000_2000, 3, 0, "zero_wait");
   endtask

   task automatic test_len0();
      clear_logs();
      pulse_start(32'h0000_3000, 32'h0000_4000, 16'd0);
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL len0_busy: got %b expected 1", busy); end
      repeat (5) tick();
      tests++;
      if (cyc_n !== 0) begin fails++; $display("FAIL len0_cyc: got %0d cycles expected 0", cyc_n); end
      tests++;
      if (done_n !== 1 || done_at - t0 !== 2) begin
         fails++; $display("FAIL len0_done: got %0d pulses at +%0d expected 1 at +2", done_n, done_at - t0);
      end
   endtask

   task automatic test_timeout();
      int k;
      nack = 1'b1;
      clear_logs();
      pulse_start(32'h0000_4000, 32'h0000_5000, 16'd1);
      k = 0;
      while (err_n == 0 && k < 200) begin tick(); k++; end
      tests++;
      if (k >= 200) begin fails++; $display("FAIL timeout_wait: no err within 200 cycles"); end
      repeat (3) tick();
      tests++;
      if (cyc_n !== TMO) begin fails++; $display("FAIL timeout_cyc: got %0d cycles expected %0d", cyc_n, TMO); end
      tests++;
      if (err_n !== 1 || done_n !== 0) begin
         fails++; $display("FAIL timeout_pulses: got err %0d done %0d expected 1/0", err_n, done_n);
      end
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL timeout_busy: got %b expected 0", busy); end
      nack = 1'b0;
   endtask

   task automatic test_wrap();
      copy(32'hFFFF_FFFD, 32'h0000_5002, 2, 0, "wrap");
      tests++;
      if (rd_adr.size() != 2 || rd_adr[1] !== 32'h0000_0000) begin
         fails++; $display("FAIL wrap_rd1: got %0d reads, expected second read at 00000000", rd_adr.size());
      end
   endtask

   task automatic test_reset_busy();
      int k;
      logic [31:0] wadr;
      for (int i = 0; i < 4; i++) mem[32'h6000 + 32'(4 * i)] = $urandom;
      lat = 1;
      clear_logs();
      pulse_start(32'h0000_6000, 32'h0000_A000, 16'd4);
      k = 0;
      while (!stb && k < 20) begin tick(); k++; end
      src = 32'h0000_9000; dst = 32'h0000_B000; len = 16'd7; start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (!(stb && we && wr_adr.size() == 1) && k < 100) begin tick(); k++; end
      tests++;
      if (k >= 100) begin fails++; $display("FAIL rstbusy_wait: second write never issued"); end
      wadr = adr;
      rst_n = 1'b0;
      tick();
      tests++;
      if (cyc !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rstbusy_cyc: got cyc %b busy %b expected 0/0", cyc, busy); end
      rst_n = 1'b1;
      repeat (8) tick();
      tests++;
      if (done_n !== 0 || err_n !== 0) begin fails++; $display("FAIL rstbusy_pulses: got done %0d err %0d expected 0/0", done_n, err_n); end
      tests++;
      if (wadr !== 32'h0000_A004) begin fails++; $display("FAIL rstbusy_wadr: got %h expected 0000a004", wadr); end
      tests++;
      if (rd_adr.size() != 2 || rd_adr[0] !== 32'h0000_6000 || rd_adr[1] !== 32'h0000_6004) begin
         fails++; $display("FAIL rstbusy_reads: got %0d reads, expected 00006000,00006004", rd_adr.size());
      end
      tests++;
      if (wr_adr.size() != 1 || wr_adr[0] !== 32'h0000_A000) begin
         fails++; $display("FAIL rstbusy_writes: got %0d writes, expected one at 0000a000", wr_adr.size());
      end
   endtask

   task automatic test_wait_states();
      mon_en = 1'b1;
      copy(32'h0000_7000, 32'h0000_8000, 3, 3, "wait3");
      mon_en = 1'b0;
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++)
         copy(32'h1000_0000 | ($urandom & 32'h00FF_FFFF), 32'h2000_0000 | ($urandom & 32'h00FF_FFFF),
              int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), "random");
   endtask

   initial begin
      repeat (3) tick();
      test_reset();
      rst_n = 1'b1;
      tick();
      test_zero_wait();
      test_len0();
      test_timeout();
      test_wrap();
      test_reset_busy();
      test_wait_states();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
